sub_seq: RTL

Limb-serial multi-precision subtractor sequencer for the Karatsuba multiplier datapath. It accepts two unsigned W = N_BITS*N_LIMBS operands and computes their difference one N_BITS limb per cycle through a single shared limb subtractor, chaining the borrow between limbs. It optionally returns |a-b| plus sign, which is what the Karatsuba middle-term stage consumes. It sits between the operand-splitting stage and the recursive multiply stage, with valid/ready handshakes on both sides.

---
 rtl/sub_seq_pkg.sv | 22 ++
 rtl/sub_seq_limb_sub.sv | 17 +
 rtl/sub_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sub_seq_pkg.sv
// Shared types and sizing helpers for the limb-serial subtractor sequencer.
// The optional |a-b| mode is controlled by the SUB_SEQ_ABS_EN macro in sub_seq.sv.
package sub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Total operand width in bits.
  function automatic int sub_seq_w(input int n_bits, input int n_limbs);
    return n_bits * n_limbs;
  endfunction

  // Limb counter width; never narrower than one bit.
  function automatic int sub_seq_kw(input int n_limbs);
    return (n_limbs > 1) ? $clog2(n_limbs) : 1;
  endfunction

endpackage

// File: rtl/sub_seq_limb_sub.sv
// Single-limb subtractor with borrow in/out: d = x - y - bin.
module limb_sub #(
  parameter int N_BITS = 4
) (
  input  logic [N_BITS-1:0] x,
  input  logic [N_BITS-1:0] y,
  input  logic              bin,
  output logic [N_BITS-1:0] d,
  output logic              bout
);

  // One extra bit catches the borrow: the result is negative iff the top bit is set.
  always_comb begin
    {bout, d} = {1'b0, x} - {1'b0, y} - {{N_BITS{1'b0}}, bin};
  end

endmodule

// File: rtl/sub_seq.sv
// Limb-serial multi-precision subtractor sequencer.
// Optional feature macro: SUB_SEQ_ABS_EN -- when defined, a negative result is
// negated limb-serially in a NEG pass so diff = |a-b| and borrow = sign.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and in_ready/out_valid are decoded
// purely from the registered state (no input-to-output combinational paths).
module sub_seq
  import sub_seq_pkg::*;
#(
  parameter int  N_BITS  = 4,
  parameter int  N_LIMBS = 4,
  localparam int W       = sub_seq_w(N_BITS, N_LIMBS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow,
  output state_t       dbg_state
);

  localparam int            KW     = sub_seq_kw(N_LIMBS);
  localparam logic [KW-1:0] K_LAST = KW'(N_LIMBS - 1);

  state_t              state_q;
  logic [KW-1:0]       k_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [W-1:0]        diff_q;
  logic                bin_q;
  logic                borrow_q;

  int                  limb_lo;
  logic [N_BITS-1:0]   x_d;
  logic [N_BITS-1:0]   y_d;
  logic [N_BITS-1:0]   d_d;
  logic                bout_d;

  // Operand mux into the shared limb subtractor: a-b in SUB, 0-diff in NEG.
  always_comb begin
    limb_lo = int'(k_q) * N_BITS;
    x_d     = a_q[limb_lo +: N_BITS];
    y_d     = b_q[limb_lo +: N_BITS];
`ifdef SUB_SEQ_ABS_EN
    if (state_q == NEG) begin
      x_d = '0;
      y_d = diff_q[limb_lo +: N_BITS];
    end
`endif
  end

  limb_sub #(
    .N_BITS(N_BITS)
  ) u_limb_sub (
    .x   (x_d),
    .y   (y_d),
    .bin (bin_q),
    .d   (d_d),
    .bout(bout_d)
  );

  // Sequencer FSM: capture, limb-serial subtract (and optional negate), hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            k_q      <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            state_q  <= SUB;
          end
        end
        SUB: begin
          diff_q[limb_lo +: N_BITS] <= d_d;
          bin_q                     <= bout_d;
          k_q                       <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            borrow_q <= bout_d;
            k_q      <= '0;
            bin_q    <= 1'b0;
`ifdef SUB_SEQ_ABS_EN
            state_q  <= bout_d ? NEG : DONE;
`else
            state_q  <= DONE;
`endif
          end
        end
`ifdef SUB_SEQ_ABS_EN
        NEG: begin
          diff_q[limb_lo +: N_BITS] <= d_d;
          bin_q                     <= bout_d;
          k_q                       <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            k_q     <= '0;
            bin_q   <= 1'b0;
            state_q <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign dbg_state = state_q;

endmodule
